// File: rtl/rf_wb_arbiter_pkg.sv
// Shared core types for the register-file write-back path.
// The package is named core_pkg because other core blocks share it.
package core_pkg;
   localparam int XLEN       = 32;
   localparam int NUM_REGS   = 32;
   localparam int REG_ADDR_W = 5;

   typedef struct packed {
      logic [REG_ADDR_W-1:0] rd;
      logic [XLEN-1:0]       data;
   } wb_req_t;
endpackage

// File: rtl/rf_wb_arbiter_if.sv
// Write-back arbiter handshake bundle: ALU results, load issue/response, register-file write port.
// The slave modport is the arbiter side; the master modport is the pipeline/memory side.
interface rf_wb_arbiter_if #(
   parameter int XLEN     = core_pkg::XLEN,
   parameter int LD_DEPTH = 4
);
   localparam int CNT_W = $clog2(LD_DEPTH + 1);

   logic                            alu_valid_i;
   logic                            alu_ready_o;
   logic [core_pkg::REG_ADDR_W-1:0] alu_rd_i;
   logic [XLEN-1:0]                 alu_data_i;
   logic                            ld_issue_i;
   logic [core_pkg::REG_ADDR_W-1:0] ld_issue_rd_i;
   logic                            ld_issue_ready_o;
   logic                            ld_valid_i;
   logic [core_pkg::REG_ADDR_W-1:0] ld_rd_i;
   logic [XLEN-1:0]                 ld_data_i;
   logic                            rf_wen_o;
   logic [core_pkg::REG_ADDR_W-1:0] rf_waddr_o;
   logic [XLEN-1:0]                 rf_wdata_o;
   logic [core_pkg::NUM_REGS-1:0]   busy_o;
   logic [CNT_W-1:0]                ld_cnt_o;

   modport slave (
      input  alu_valid_i, alu_rd_i, alu_data_i,
      input  ld_issue_i, ld_issue_rd_i, ld_valid_i, ld_rd_i, ld_data_i,
      output alu_ready_o, ld_issue_ready_o,
      output rf_wen_o, rf_waddr_o, rf_wdata_o, busy_o, ld_cnt_o
   );

   modport master (
      output alu_valid_i, alu_rd_i, alu_data_i,
      output ld_issue_i, ld_issue_rd_i, ld_valid_i, ld_rd_i, ld_data_i,
      input  alu_ready_o, ld_issue_ready_o,
      input  rf_wen_o, rf_waddr_o, rf_wdata_o, busy_o, ld_cnt_o
   );
endinterface

// File: rtl/rf_wb_arbiter_ld_resp_fifo.sv
// Synchronous FIFO holding load responses that lost write-port arbitration.
// Pointers wrap naturally; an occupancy counter separates full from empty.
module ld_resp_fifo
   import core_pkg::*;
#(
   parameter int DEPTH = 4
) (
   input  logic                         clk_i,
   input  logic                         rst_ni,
   input  logic                         push_i,
   input  wb_req_t                      push_data_i,
   input  logic                         pop_i,
   output wb_req_t                      head_o,
   output logic                         empty_o,
   output logic                         full_o,
   output logic [$clog2(DEPTH+1)-1:0]   count_o
);
   localparam int PTR_W = $clog2(DEPTH);
   localparam int CNT_W = $clog2(DEPTH + 1);
   localparam logic [CNT_W-1:0] FULL_CNT = CNT_W'(DEPTH);

   wb_req_t          mem_q [DEPTH];
   logic [PTR_W-1:0] wr_ptr_q, rd_ptr_q;
   logic [CNT_W-1:0] count_q, count_d;
   logic             do_push, do_pop;

   // A push into a full FIFO is only taken when the head leaves in the same cycle.
   assign do_pop  = pop_i && (count_q != '0);
   assign do_push = push_i && ((count_q != FULL_CNT) || do_pop);

   always_comb begin
      count_d = count_q;
      case ({do_push, do_pop})
         2'b10:   count_d = count_q + 1'b1;
         2'b01:   count_d = count_q - 1'b1;
         default: count_d = count_q;
      endcase
   end

   always_ff @(posedge clk_i or negedge rst_ni) begin
      if (!rst_ni) begin
         wr_ptr_q <= '0;
         rd_ptr_q <= '0;
         count_q  <= '0;
      end else begin
         if (do_push) wr_ptr_q <= wr_ptr_q + 1'b1;
         if (do_pop)  rd_ptr_q <= rd_ptr_q + 1'b1;
         count_q <= count_d;
      end
   end

   always_ff @(posedge clk_i) begin
      if (do_push) mem_q[wr_ptr_q] <= push_data_i;
   end

   assign head_o  = mem_q[rd_ptr_q];
   assign empty_o = (count_q == '0);
   assign full_o  = (count_q == FULL_CNT);
   assign count_o = count_q;
endmodule

// File: rtl/rf_wb_arbiter.sv
// Owner of the register file's single write port: merges buffered/bypassed load
// responses with back-pressurable ALU results and tracks outstanding loads per register.
module rf_wb_arbiter
   import core_pkg::*;
#(
   parameter int LD_DEPTH = 4,
   parameter int XLEN     = core_pkg::XLEN
) (
   input  logic            clk_i,
   input  logic            rst_ni,
   rf_wb_arbiter_if.slave  wb
);
   localparam int CNT_W = $clog2(LD_DEPTH + 1);
   localparam logic [CNT_W-1:0] MAX_CNT = CNT_W'(LD_DEPTH);

   logic                  fifo_empty, fifo_full, fifo_push, fifo_pop;
   logic [CNT_W-1:0]      fifo_count;
   wb_req_t               fifo_head, ld_req;

   logic [CNT_W-1:0]      ld_cnt_q, ld_cnt_d;
   logic [NUM_REGS-1:0]   busy_q, busy_d;
   logic                  wen_q, wen_d;
   logic [REG_ADDR_W-1:0] waddr_q, waddr_d;
   logic [XLEN-1:0]       wdata_q, wdata_d;

   logic                  issue_acc, alu_hold, alu_rdy;
   logic                  win_valid, win_is_ld;
   wb_req_t               win;
   logic                  unused_fifo_status;

   assign ld_req = '{rd: wb.ld_rd_i, data: wb.ld_data_i};

   ld_resp_fifo #(.DEPTH(LD_DEPTH)) u_ld_fifo (
      .clk_i       (clk_i),
      .rst_ni      (rst_ni),
      .push_i      (fifo_push),
      .push_data_i (ld_req),
      .pop_i       (fifo_pop),
      .head_o      (fifo_head),
      .empty_o     (fifo_empty),
      .full_o      (fifo_full),
      .count_o     (fifo_count)
   );

   // The outstanding-load limit already bounds FIFO occupancy, so its status is not consulted.
   assign unused_fifo_status = ^{fifo_full, fifo_count};

   always_comb begin
      issue_acc = wb.ld_issue_i && (ld_cnt_q < MAX_CNT);
      alu_hold  = (wb.alu_rd_i != '0) && busy_q[wb.alu_rd_i];
      alu_rdy   = rst_ni && fifo_empty && !wb.ld_valid_i && !alu_hold;

      // Fixed priority: FIFO head, then bypassed response, then ALU.
      win_valid = 1'b0;
      win_is_ld = 1'b0;
      win       = '{rd: '0, data: '0};
      if (!fifo_empty) begin
         win_valid = 1'b1;
         win_is_ld = 1'b1;
         win       = fifo_head;
      end else if (wb.ld_valid_i) begin
         win_valid = 1'b1;
         win_is_ld = 1'b1;
         win       = ld_req;
      end else if (wb.alu_valid_i && alu_rdy) begin
         win_valid = 1'b1;
         win       = '{rd: wb.alu_rd_i, data: wb.alu_data_i};
      end

      fifo_pop  = !fifo_empty;
      fifo_push = wb.ld_valid_i && !fifo_empty;

      // Clear first so that a same-cycle set on the same register wins.
      busy_d = busy_q;
      if (win_is_ld && (win.rd != '0)) busy_d[win.rd] = 1'b0;
      if (issue_acc && (wb.ld_issue_rd_i != '0)) busy_d[wb.ld_issue_rd_i] = 1'b1;

      ld_cnt_d = ld_cnt_q;
      case ({issue_acc, win_is_ld})
         2'b10:   ld_cnt_d = ld_cnt_q + 1'b1;
         2'b01:   ld_cnt_d = ld_cnt_q - 1'b1;
         default: ld_cnt_d = ld_cnt_q;
      endcase

      wen_d   = win_valid && (win.rd != '0);
      waddr_d = win_valid ? win.rd   : waddr_q;
      wdata_d = win_valid ? win.data : wdata_q;
   end

   always_ff @(posedge clk_i or negedge rst_ni) begin
      if (!rst_ni) begin
         ld_cnt_q <= '0;
         busy_q   <= '0;
         wen_q    <= 1'b0;
         waddr_q  <= '0;
         wdata_q  <= '0;
      end else begin
         ld_cnt_q <= ld_cnt_d;
         busy_q   <= busy_d;
         wen_q    <= wen_d;
         waddr_q  <= waddr_d;
         wdata_q  <= wdata_d;
      end
   end

   assign wb.alu_ready_o      = alu_rdy;
   assign wb.ld_issue_ready_o = (ld_cnt_q < MAX_CNT);
   assign wb.rf_wen_o         = wen_q;
   assign wb.rf_waddr_o       = waddr_q;
   assign wb.rf_wdata_o       = wdata_q;
   assign wb.busy_o           = busy_q;
   assign wb.ld_cnt_o         = ld_cnt_q;
endmodule
